// File: rtl/lin_approx_counter.sv
`default_nettype none
// ============================================================================
// lin_approx_counter : per-channel linear-approximation hit counter with
//                      parity FIFO aligning plaintext and ciphertext parities.
// Revision: 1.0
// ============================================================================
module lin_approx_counter #(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 16,
  parameter int LIMIT_W    = 20,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [LIMIT_W-1:0]      msg_limit,
  input  logic [NUM_CH*64-1:0]    mask_i,
  input  logic [NUM_CH*64-1:0]    mask_o,
  input  logic                    msg_valid,
  input  logic [63:0]             message,
  output logic                    msg_ready,
  input  logic                    ct_valid,
  input  logic [63:0]             ciphertext,
  output logic [NUM_CH*CNT_W-1:0] counters,
  output logic                    busy,
  output logic                    done,
  output logic                    err_underflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [LIMIT_W-1:0] LIMIT_ONE = {{(LIMIT_W-1){1'b0}}, 1'b1};
  localparam logic [AW:0]        PTR_ONE   = {{AW{1'b0}}, 1'b1};

  logic [1:0]               state_q, state_d;
  logic [NUM_CH*64-1:0]     mask_i_q, mask_i_d, mask_o_q, mask_o_d;
  logic [LIMIT_W-1:0]       limit_q, limit_d, msg_cnt_q, msg_cnt_d;
  logic [AW:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NUM_CH-1:0]        hit_q, hit_d;
  logic                     hit_v_q, hit_v_d;
  logic [NUM_CH*CNT_W-1:0]  cnt_q, cnt_d;
  logic                     err_q, err_d;

  logic [NUM_CH-1:0]        fifo_mem [FIFO_DEPTH];
  logic [NUM_CH-1:0]        p_i, p_o, fifo_head;
  logic                     fifo_empty, fifo_full, push, pop, start_acc;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign fifo_head  = fifo_mem[rd_ptr_q[AW-1:0]];
  assign start_acc  = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign push       = msg_valid && msg_ready;
  assign pop        = ct_valid && !fifo_empty;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign p_i[k] = ^(message    & mask_i_q[64*k +: 64]);
    assign p_o[k] = ^(ciphertext & mask_o_q[64*k +: 64]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = (msg_limit == '0) ? S_DRAIN : S_RUN;
      S_RUN:   if (push && ((msg_cnt_q + LIMIT_ONE) == limit_q)) state_d = S_DRAIN;
      S_DRAIN: if (fifo_empty && !ct_valid && !hit_v_q) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    msg_ready = (state_q == S_RUN) && (msg_cnt_q < limit_q) && !fifo_full;
    busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
    done      = (state_q == S_DONE);
  end

  always_comb begin
    mask_i_d  = mask_i_q;
    mask_o_d  = mask_o_q;
    limit_d   = limit_q;
    msg_cnt_d = msg_cnt_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    hit_d     = hit_q;
    hit_v_d   = 1'b0;
    cnt_d     = cnt_q;
    err_d     = err_q;
    if (start_acc) begin
      mask_i_d  = mask_i;
      mask_o_d  = mask_o;
      limit_d   = msg_limit;
      msg_cnt_d = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      hit_d     = '0;
      cnt_d     = '0;
      err_d     = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d  = wr_ptr_q + PTR_ONE;
        msg_cnt_d = msg_cnt_q + LIMIT_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        hit_d    = fifo_head ^ p_o;
        hit_v_d  = 1'b1;
      end
      // A ciphertext with no matching plaintext parity is dropped and flagged.
      if (ct_valid && fifo_empty) err_d = 1'b1;
      for (int k = 0; k < NUM_CH; k++) begin
        if (hit_v_q && hit_q[k] && (cnt_q[CNT_W*k +: CNT_W] != CNT_MAX))
          cnt_d[CNT_W*k +: CNT_W] = cnt_q[CNT_W*k +: CNT_W] + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_i_q  <= '0;
      mask_o_q  <= '0;
      limit_q   <= '0;
      msg_cnt_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      hit_q     <= '0;
      hit_v_q   <= 1'b0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      mask_i_q  <= mask_i_d;
      mask_o_q  <= mask_o_d;
      limit_q   <= limit_d;
      msg_cnt_q <= msg_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      hit_q     <= hit_d;
      hit_v_q   <= hit_v_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  // Storage needs no reset: occupancy is defined entirely by the pointers.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q[AW-1:0]] <= p_i;
  end

  assign counters      = cnt_q;
  assign err_underflow = err_q;

endmodule
`default_nettype wire

// File: tb/tb_lin_approx_counter.sv
`default_nettype none
// ============================================================================
// tb_lin_approx_counter : scoreboard bench for lin_approx_counter.
// Revision: 1.0
// ============================================================================
module tb_lin_approx_counter;

  localparam int NUM_CH     = 4;
  localparam int CNT_W      = 4;
  localparam int LIMIT_W    = 20;
  localparam int FIFO_DEPTH = 32;
  localparam int LAT        = 18;
  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    start = 1'b0;
  logic [LIMIT_W-1:0]      msg_limit = '0;
  logic [NUM_CH*64-1:0]    mask_i = '0, mask_o = '0;
  logic                    msg_valid = 1'b0;
  logic [63:0]             message = '0;
  logic                    msg_ready;
  logic                    ct_valid = 1'b0;
  logic [63:0]             ciphertext = '0;
  logic [NUM_CH*CNT_W-1:0] counters;
  logic                    busy, done, err_underflow;

  int checks = 0;
  int errors = 0;

  logic [NUM_CH*64-1:0] mi_lat, mo_lat;
  logic [CNT_W-1:0]     exp_cnt [NUM_CH];
  logic [NUM_CH-1:0]    pi_q [$];
  int                   due_q [$];
  logic [63:0]          msg_src [$];

  lin_approx_counter #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .LIMIT_W(LIMIT_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .msg_limit(msg_limit),
    .mask_i(mask_i), .mask_o(mask_o), .msg_valid(msg_valid), .message(message),
    .msg_ready(msg_ready), .ct_valid(ct_valid), .ciphertext(ciphertext),
    .counters(counters), .busy(busy), .done(done), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NUM_CH-1:0] par_vec(input logic [63:0] d, input logic [NUM_CH*64-1:0] m);
    logic [NUM_CH-1:0] v;
    for (int k = 0; k < NUM_CH; k++) v[k] = ^(d & m[64*k +: 64]);
    return v;
  endfunction

  function automatic logic [NUM_CH*CNT_W-1:0] exp_vec();
    logic [NUM_CH*CNT_W-1:0] v;
    for (int k = 0; k < NUM_CH; k++) v[CNT_W*k +: CNT_W] = exp_cnt[k];
    return v;
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < NUM_CH; k++) exp_cnt[k] = '0;
    pi_q.delete();
    due_q.delete();
  endfunction

  // Scoreboard side of a ciphertext: pop the oldest plaintext parity.
  function automatic void model_ct(input logic [63:0] ct);
    logic [NUM_CH-1:0] h;
    if (pi_q.size() == 0) return;
    h = pi_q.pop_front() ^ par_vec(ct, mo_lat);
    for (int k = 0; k < NUM_CH; k++)
      if (h[k] && exp_cnt[k] != CMAX) exp_cnt[k] = exp_cnt[k] + 1'b1;
  endfunction

  task automatic do_start(input logic [LIMIT_W-1:0] lim, input logic [NUM_CH*64-1:0] mi,
                          input logic [NUM_CH*64-1:0] mo);
    mask_i = mi; mask_o = mo; msg_limit = lim; start = 1'b1;
    tick();
    start = 1'b0;
    mi_lat = mi; mo_lat = mo;
    model_clear();
    for (int k = 0; k < NUM_CH*2; k++) begin
      mask_i[32*k +: 32] = $urandom;
      mask_o[32*k +: 32] = $urandom;
    end
  endtask

  task automatic run_stream(input string name);
    int cyc = 0;
    int sent = 0;
    int n = msg_src.size();
    if (busy !== 1'b1) begin
      errors++; $display("FAIL %s_busy: actual=%b required=1", name, busy);
    end
    checks++;
    while ((sent < n || due_q.size() > 0) && cyc < 2000) begin
      msg_valid = (sent < n);
      message   = (sent < n) ? msg_src[sent] : 64'h0;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        ct_valid   = 1'b1;
        ciphertext = {$urandom, $urandom};
        void'(due_q.pop_front());
        model_ct(ciphertext);
      end else begin
        ct_valid = 1'b0;
      end
      if (msg_valid && msg_ready) begin
        pi_q.push_back(par_vec(message, mi_lat));
        due_q.push_back(cyc + LAT);
        sent++;
      end
      tick();
      cyc++;
    end
    msg_valid = 1'b0;
    ct_valid  = 1'b0;
    if (cyc >= 2000) begin
      errors++; $display("FAIL %s_timeout: actual=sent %0d required=%0d", name, sent, n);
    end
    checks++;
    tick();
    if (counters !== exp_vec() || done !== 1'b0) begin
      errors++;
      $display("FAIL %s_counters: actual=%h done=%b required=%h done=0", name, counters, done, exp_vec());
    end
    checks++;
    tick();
    if (done !== 1'b1 || busy !== 1'b0 || err_underflow !== 1'b0 || counters !== exp_vec()) begin
      errors++;
      $display("FAIL %s_done: actual=done %b busy %b err %b cnt %h required=done 1 busy 0 err 0 cnt %h",
               name, done, busy, err_underflow, counters, exp_vec());
    end
    checks++;
  endtask

  task automatic test_reset();
    tick(); tick();
    rst_n = 1'b1;
    if ({msg_ready, busy, done, err_underflow} !== 4'b0 || counters !== '0) begin
      errors++;
      $display("FAIL reset: actual=rdy %b busy %b done %b err %b cnt %h required=all 0",
               msg_ready, busy, done, err_underflow, counters);
    end
    checks++;
    tick();
  endtask

  task automatic test_zero_masks();
    do_start(20'd5, '0, '0);
    msg_src.delete();
    for (int i = 0; i < 5; i++) msg_src.push_back({$urandom, $urandom});
    run_stream("zero_masks");
  endtask

  task automatic test_odd_msgs();
    logic [NUM_CH*64-1:0] mi = '0;
    mi[63:0] = 64'h1;
    do_start(20'd4, mi, '0);
    msg_src.delete();
    for (int i = 1; i <= 4; i++) msg_src.push_back(64'(i));
    run_stream("odd_msgs");
    if (counters[CNT_W-1:0] !== 4'd2) begin
      errors++; $display("FAIL odd_msgs_ch0: actual=%0d required=2", counters[CNT_W-1:0]);
    end
    checks++;
  endtask

  task automatic test_random_masks();
    logic [NUM_CH*64-1:0] mi, mo;
    for (int k = 0; k < NUM_CH*2; k++) begin
      mi[32*k +: 32] = $urandom;
      mo[32*k +: 32] = $urandom;
    end
    do_start(20'd12, mi, mo);
    msg_src.delete();
    for (int i = 0; i < 12; i++) msg_src.push_back({$urandom, $urandom});
    run_stream("random_masks");
  endtask

  task automatic test_saturation();
    logic [NUM_CH*64-1:0] mi;
    for (int k = 0; k < NUM_CH; k++) mi[64*k +: 64] = 64'h1;
    do_start(20'd20, mi, '0);
    msg_src.delete();
    for (int i = 0; i < 20; i++) msg_src.push_back(64'h1);
    run_stream("saturation");
    if (counters !== {NUM_CH{CMAX}}) begin
      errors++; $display("FAIL saturation_value: actual=%h required=%h", counters, {NUM_CH{CMAX}});
    end
    checks++;
  endtask

  task automatic test_fifo_full_and_reset();
    logic [NUM_CH*64-1:0] mi = '0;
    int acc = 0;
    mi[63:0] = 64'h1;
    do_start(20'd40, mi, '0);
    msg_valid = 1'b1;
    message   = 64'h1;
    for (int i = 0; i < 40; i++) begin
      if (msg_ready) begin acc++; pi_q.push_back(par_vec(message, mi_lat)); end
      tick();
    end
    if (acc !== 32 || msg_ready !== 1'b0) begin
      errors++; $display("FAIL fifo_full: actual=%0d accepts rdy %b required=32 rdy 0", acc, msg_ready);
    end
    checks++;
    ct_valid = 1'b1; ciphertext = 64'h0;
    model_ct(ciphertext);
    tick();
    ct_valid = 1'b0;
    if (msg_ready !== 1'b1) begin
      errors++; $display("FAIL fifo_reopen: actual=%b required=1", msg_ready);
    end
    checks++;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      if (msg_ready) acc++;
      tick();
    end
    if (acc !== 1 || counters !== exp_vec()) begin
      errors++;
      $display("FAIL fifo_one_accept: actual=%0d cnt %h required=1 cnt %h", acc, counters, exp_vec());
    end
    checks++;
    #3 rst_n = 1'b0;
    #1;
    if ({msg_ready, busy, done, err_underflow} !== 4'b0 || counters !== '0) begin
      errors++;
      $display("FAIL async_reset: actual=rdy %b busy %b done %b err %b cnt %h required=all 0",
               msg_ready, busy, done, err_underflow, counters);
    end
    checks++;
    msg_valid = 1'b0;
    model_clear();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_underflow_idle();
    ct_valid = 1'b1; ciphertext = {$urandom, $urandom};
    tick();
    ct_valid = 1'b0;
    tick();
    if (err_underflow !== 1'b1 || counters !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL underflow_idle: actual=err %b cnt %h busy %b required=err 1 cnt 0 busy 0",
               err_underflow, counters, busy);
    end
    checks++;
  endtask

  task automatic test_limit_zero();
    int rdy_seen = 0;
    msg_valid = 1'b1; message = 64'h1;
    do_start(20'd0, '1, '1);
    if (err_underflow !== 1'b0) begin
      errors++; $display("FAIL start_clears_err: actual=%b required=0", err_underflow);
    end
    checks++;
    for (int i = 0; i < 2 && done !== 1'b1; i++) begin
      if (msg_ready) rdy_seen++;
      tick();
    end
    if (done !== 1'b1) begin
      errors++; $display("FAIL limit_zero_done: actual=%b required=1", done);
    end
    checks++;
    for (int i = 0; i < 4; i++) begin
      if (msg_ready) rdy_seen++;
      tick();
    end
    if (rdy_seen != 0 || counters !== '0) begin
      errors++; $display("FAIL limit_zero_ready: actual=%0d ready cycles required=0", rdy_seen);
    end
    checks++;
    msg_valid = 1'b0;
  endtask

  initial begin
    model_clear();
    test_reset();
    test_zero_masks();
    test_odd_msgs();
    test_random_masks();
    test_saturation();
    test_fifo_full_and_reset();
    test_underflow_idle();
    test_limit_zero();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lin_approx_counter.md
Name: lin_approx_counter

Overview:
- Multi-channel linear-approximation counter for the DES attack datapath.
- Accepts a plaintext stream and, from the pipelined DES core, the matching ciphertext stream.
- Aligns the per-channel input-mask parity with the output-mask parity through an internal parity FIFO rather than a fixed delay line.
- Counts, per channel, how many plaintext/ciphertext pairs give an approximation XOR of 1, over a programmable message budget. Handshakes with the message source and reports completion.

Parameters:
- NUM_CH, 4, number of independent (mask_i, mask_o) channels.
- CNT_W, 16, width of each per-channel hit counter (saturating).
- LIMIT_W, 20, width of the message budget and message counter.
- FIFO_DEPTH, 32, parity FIFO entries; power of two, at least the DES core latency (18).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active low
- start  in  1  one-cycle pulse; latches masks and budget, clears counters, begins a run
- msg_limit  in  LIMIT_W  number of messages to accept this run
- mask_i  in  NUM_CH*64  input masks; channel k = bits [64k+63:64k]
- mask_o  in  NUM_CH*64  output masks, same packing
- msg_valid  in  1  message is valid
- message  in  64  plaintext, also driven to the DES core by the source
- msg_ready  out  1  block accepts the message this cycle
- ct_valid  in  1  ciphertext from the DES core is valid (no backpressure)
- ciphertext  in  64  DES core result
- counters  out  NUM_CH*CNT_W  hit counts; channel k = bits [CNT_W*k+CNT_W-1:CNT_W*k]
- busy  out  1  high in RUN or DRAIN
- done  out  1  high in DONE
- err_underflow  out  1  sticky; ct_valid seen with parity FIFO empty

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; msg_ready=0, busy=0, done=0, err_underflow=0.
  - All counters=0; FIFO empty; message count=0; hit stage invalid; mask and limit registers=0.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE or DONE, start=1:
  - latch mask_i, mask_o and msg_limit; clear counters, message count, err_underflow and FIFO.
  - go to RUN, or straight to DRAIN if msg_limit=0.
- RUN, start=1: ignored. DRAIN, start=1: ignored.
- RUN:
  - msg_ready = (msg_cnt < limit) && !fifo_full.
  - Accept = msg_valid && msg_ready. On accept: push NUM_CH-bit vector p_i[k] = ^(message & mask_i_reg[k]); msg_cnt += 1.
  - When the accept makes msg_cnt == limit, next state is DRAIN.
- DRAIN: msg_ready=0. Go to DONE when FIFO is empty, no ct_valid this cycle, and the hit stage is invalid.
- DONE: done=1 until the next start. Counters hold their values.
- Ciphertext path, any state:
  - On ct_valid with FIFO non-empty: pop the head; hit[k] = head[k] ^ (^(ciphertext & mask_o_reg[k])); register hit and hit_v.
  - Next cycle, each counter with hit[k]=1 increments, saturating at 2^CNT_W-1 (no wrap).
  - Counter reflects a ciphertext 2 clk edges after ct_valid is sampled.
- ct_valid with FIFO empty: sample dropped; err_underflow <= 1 (sticky until start or reset).
- FIFO push and pop in the same cycle are legal:
  - occupancy unchanged;
  - when the FIFO is full, msg_ready is already 0, so no push can occur.
- Masks are used only from the latched registers; input changes mid-run have no effect.
- Reset mid-run: immediate return to the reset values above. In-flight core results are then flagged by err_underflow.

Test Plan:
- NUM_CH=4, msg_limit=5, all masks 0, five messages, ct_valid 18 cycles after each message -> all counters 0, done=1, err_underflow=0.
- mask_i[0]=64'h1, mask_o[0]=64'h0, messages 1,2,3,4 (limit 4), arbitrary ciphertexts -> counter[0]=2 (odd messages), DONE entered the cycle after the last hit stage drains.
- FIFO_DEPTH=32, msg_valid held high, ct_valid held low -> msg_ready drops after 32 accepts; one ct_valid then re-asserts msg_ready for exactly one accept.
- CNT_W=4, every pair gives hit=1, limit 20 -> counter saturates at 15 and stays at 15.
- ct_valid pulse in IDLE -> err_underflow=1, counters unchanged; next start clears err_underflow.
- start with msg_limit=0 -> msg_ready never asserts, done=1 within 2 cycles; rst_n low mid-RUN -> all outputs return to reset values asynchronously.
